// File: rtl/learn_pkg.sv
// Shared types and constants for the learn sweep sequencer and its peak detector.
package learn_pkg;

  localparam int AMP_W       = 10;
  localparam int ACC_W       = 12;
  localparam int IDX_W       = 4;
  localparam int N_STEPS_DEF = 10;
  localparam int START_CODE  = 10;
  localparam int FREQ_STEP   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_MEAS   = 3'd3,
    ST_STORE  = 3'd4,
    ST_STEP   = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

endpackage

// File: rtl/learn_sweep_seq_peak_meas.sv
// Running max/min tracker of ADC samples; clear restarts a measurement window.
module peak_meas
  import learn_pkg::*;
(
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             adc_valid,
  input  logic [AMP_W-1:0] adc_data,
  output logic [AMP_W-1:0] max_val,
  output logic [AMP_W-1:0] min_val,
  output logic             seen
);

  // Trackers start at opposite extremes so the first sample sets both.
  always_ff @(posedge clk_50m) begin
    if (!rst_n || clear) begin
      max_val <= '0;
      min_val <= '1;
      seen    <= 1'b0;
    end else if (adc_valid) begin
      if (adc_data > max_val) max_val <= adc_data;
      if (adc_data < min_val) min_val <= adc_data;
      seen <= 1'b1;
    end
  end

endmodule

// File: rtl/learn_sweep_seq.sv
// Learn sweep sequencer: steps the DDS frequency and records ADC amplitude per step.
// LEARN_AVG_EN: average four measurement windows per step.
// Handshake: start/abort are single-cycle strobes, abort wins; adc_valid qualifies adc_data.
module learn_sweep_seq
  import learn_pkg::*;
#(
  parameter int N_STEPS    = N_STEPS_DEF,
  parameter int SETTLE_CYC = 4096,
  parameter int MEAS_CYC   = 65536,
  parameter int PULSE_W    = 2,
  parameter int ARM_CYC    = 16
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             adc_valid,
  input  logic [AMP_W-1:0] adc_data,
  output logic             learn_en,
  output logic             next_freq,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [AMP_W-1:0] rd_data,
  output logic [2:0]       dbg_state
);

  localparam int CNT_W = $clog2(ARM_CYC + SETTLE_CYC + MEAS_CYC + PULSE_W + 1);
  localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_STEPS - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [AMP_W-1:0] tbl [2**IDX_W];
  logic [AMP_W-1:0] pk_max, pk_min, amp, store_val;
  logic             pk_seen, pk_clear, meas_valid, last_win;

  assign pk_clear   = (state == ST_SETTLE) || (state == ST_STORE);
  assign meas_valid = adc_valid && (state == ST_MEAS);
  assign amp        = pk_seen ? (pk_max - pk_min) : '0;
  assign dbg_state  = state;

  peak_meas u_peak (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .adc_valid (meas_valid),
    .adc_data  (adc_data),
    .max_val   (pk_max),
    .min_val   (pk_min),
    .seen      (pk_seen)
  );

`ifdef LEARN_AVG_EN
  logic [1:0]       win;
  logic [ACC_W-1:0] acc, acc_sum, acc_rnd;

  assign acc_sum   = acc + ACC_W'(amp);
  assign acc_rnd   = acc_sum + ACC_W'(2);
  assign store_val = acc_rnd[ACC_W-1:2];
  assign last_win  = (win == 2'd3);

  always_ff @(posedge clk_50m) begin
    if (!rst_n || state == ST_SETTLE) begin
      win <= '0;
      acc <= '0;
    end else if (state == ST_STORE) begin
      win <= win + 2'd1;
      acc <= last_win ? '0 : acc_sum;
    end
  end
`else
  assign store_val = amp;
  assign last_win  = 1'b1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_ARM;
      ST_ARM:    if (cnt == ARM_LAST) state_next = ST_SETTLE;
      ST_SETTLE: if (cnt == SETTLE_LAST) state_next = ST_MEAS;
      ST_MEAS:   if (cnt == MEAS_LAST) state_next = ST_STORE;
      ST_STORE: begin
        if (!last_win)            state_next = ST_MEAS;
        else if (idx == IDX_LAST) state_next = ST_FINISH;
        else                      state_next = ST_STEP;
      end
      ST_STEP:   if (cnt == PULSE_LAST) state_next = ST_SETTLE;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Outputs are registered from the next state so they align with state entry.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      learn_en  <= 1'b0;
      next_freq <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + 1'b1;

      if (state == ST_IDLE) idx <= '0;
      else if (state == ST_STEP && state_next == ST_SETTLE) idx <= idx + 1'b1;

      if (state == ST_STORE && last_win) tbl[idx] <= store_val;

      learn_en  <= (state_next != ST_IDLE) && (state_next != ST_FINISH);
      next_freq <= (state_next == ST_STEP);
      busy      <= (state_next != ST_IDLE);
      done      <= (state_next == ST_FINISH);

      if (state_next == ST_FINISH) res_valid <= 1'b1;
      else if ((abort && state != ST_IDLE) || state_next == ST_ARM) res_valid <= 1'b0;

      rd_data <= (32'(rd_addr) < N_STEPS) ? tbl[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_learn_sweep_seq.sv
// Directed bench for learn_sweep_seq: sweep, mute, abort, reset and table readback.
module tb_learn_sweep_seq;
  import learn_pkg::*;

  localparam int N_STEPS    = 3;
  localparam int SETTLE_CYC = 8;
  localparam int MEAS_CYC   = 16;
  localparam int PULSE_W    = 2;
  localparam int ARM_CYC    = 4;
`ifdef LEARN_AVG_EN
  localparam int WINS = 4;
`else
  localparam int WINS = 1;
`endif
  // learn_en rise to first next_freq rise, in cycles.
  localparam int LAT = ARM_CYC + SETTLE_CYC + WINS * (MEAS_CYC + 1);

  logic       clk_50m, rst_n, start, abort, adc_valid;
  logic [9:0] adc_data;
  logic       learn_en, next_freq, busy, done, res_valid;
  logic [3:0] rd_addr;
  logic [9:0] rd_data;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  learn_sweep_seq #(
    .N_STEPS(N_STEPS), .SETTLE_CYC(SETTLE_CYC), .MEAS_CYC(MEAS_CYC),
    .PULSE_W(PULSE_W), .ARM_CYC(ARM_CYC)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .abort(abort),
    .adc_valid(adc_valid), .adc_data(adc_data), .learn_en(learn_en),
    .next_freq(next_freq), .busy(busy), .done(done), .res_valid(res_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  // ADC source: free-running 100..400 ramp, or a window-synchronous pattern for averaging
  logic mute = 1'b0;
  logic avg_pat = 1'b0;
  int   ph16 = 0;
  int   win = 0;
  logic tog = 1'b0;
  initial begin
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge clk_50m);
      if (avg_pat) begin
        if (dbg_state == ST_SETTLE)     win = 0;
        else if (dbg_state == ST_STORE) win = (win + 1) % 4;
        tog       = ~tog;
        adc_valid = 1'b1;
        adc_data  = tog ? 10'(500 + ((win == 0) ? 10 : 11)) : 10'd500;
      end else begin
        ph16      = (ph16 + 1) % 16;
        adc_valid = ~mute;
        adc_data  = 10'(100 + 20 * ph16);
      end
    end
  end

  // output monitor: pulse counts, widths, latency
  int   cyc = 0, nf_rises = 0, nf_bad_w = 0, nf_w = 0, done_hi = 0, last_lat = -1, le_rise_cyc = 0;
  logic nf_prev = 1'b0, le_prev = 1'b0, first_pending = 1'b0;
  initial begin
    forever begin
      @(negedge clk_50m);
      cyc++;
      if (learn_en && !le_prev) begin le_rise_cyc = cyc; first_pending = 1'b1; end
      if (next_freq && !nf_prev) begin
        nf_rises++;
        nf_w = 0;
        if (first_pending) begin last_lat = cyc - le_rise_cyc; first_pending = 1'b0; end
      end
      if (next_freq) nf_w++;
      if (!next_freq && nf_prev && nf_w != PULSE_W) nf_bad_w++;
      if (done) done_hi++;
      nf_prev = next_freq;
      le_prev = learn_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk_50m); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    check(tag, done, 1);
  endtask

  task automatic wait_nf(input string tag, input int budget);
    int n = 0;
    int base = nf_rises;
    while (nf_rises == base && n < budget) begin tick(); n++; end
    check(tag, 32'(nf_rises - base), 1);
  endtask

  task automatic wait_state(input string tag, input state_t st, input int budget);
    int n = 0;
    while (dbg_state != st && n < budget) begin tick(); n++; end
    check(tag, dbg_state, st);
  endtask

  task automatic rd_check(input string tag, input int addr);
    logic [9:0] exp;
    rd_addr = 4'(addr);
    tick();
    exp = exp_q.pop_front();
    check(tag, rd_data, exp);
  endtask

  task automatic check_all_low(input string tag);
    check({tag, ".learn_en"},  learn_en, 0);
    check({tag, ".next_freq"}, next_freq, 0);
    check({tag, ".busy"},      busy, 0);
    check({tag, ".done"},      done, 0);
    check({tag, ".res_valid"}, res_valid, 0);
    check({tag, ".state"},     dbg_state, ST_IDLE);
  endtask

  int nf0, done0;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_addr = '0;
    tick(3);
    rst_n = 1'b1;
    tick();
    check_all_low("reset");
    check("reset.rd_data", rd_data, 0);

    // normal sweep, with a redundant start mid-sweep
    exp_q.push_back(10'd300); exp_q.push_back(10'd300); exp_q.push_back(10'd300);
    exp_q.push_back(10'd0);   exp_q.push_back(10'd0);
    nf0 = nf_rises; done0 = done_hi;
    pulse_start();
    check("sweepA.learn_en_rise", learn_en, 1);
    check("sweepA.busy", busy, 1);
    wait_nf("sweepA.first_nf", 500);
    pulse_start();
    wait_done("sweepA.done", 1000);
    check("sweepA.learn_en_at_done", learn_en, 0);
    check("sweepA.res_valid", res_valid, 1);
    tick();
    check("sweepA.done_width", 32'(done_hi - done0), 1);
    check("sweepA.idle_busy", busy, 0);
    check("sweepA.nf_count", 32'(nf_rises - nf0), 2);
    check("sweepA.nf_width_bad", 32'(nf_bad_w), 0);
    check("sweepA.first_nf_latency", 32'(last_lat), 32'(LAT));
    rd_check("sweepA.tbl0", 0);
    rd_check("sweepA.tbl1", 1);
    rd_check("sweepA.tbl2", 2);
    rd_check("sweepA.addr3", 3);
    rd_check("sweepA.addr15", 15);

    // no valid samples during step 1
    exp_q.push_back(10'd300); exp_q.push_back(10'd0); exp_q.push_back(10'd300);
    pulse_start();
    check("sweepB.res_valid_cleared", res_valid, 0);
    wait_nf("sweepB.nf1", 500);
    mute = 1'b1;
    wait_nf("sweepB.nf2", 500);
    mute = 1'b0;
    wait_done("sweepB.done", 1000);
    tick();
    rd_check("sweepB.tbl0", 0);
    rd_check("sweepB.tbl1", 1);
    rd_check("sweepB.tbl2", 2);

    // abort during the second settle
    nf0 = nf_rises; done0 = done_hi;
    pulse_start();
    wait_nf("abort.nf1", 500);
    wait_state("abort.settle2", ST_SETTLE, 50);
    tick(3);
    abort = 1'b1; tick(); abort = 1'b0;
    check_all_low("abort");
    tick(200);
    check("abort.nf_count", 32'(nf_rises - nf0), 1);
    check("abort.no_done", 32'(done_hi - done0), 0);

    // start and abort together from idle
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_all_low("start_abort");
    tick(5);
    check("start_abort.later_busy", busy, 0);

    // reset pulse mid-measurement clears outputs and table
    exp_q.push_back(10'd0); exp_q.push_back(10'd0); exp_q.push_back(10'd0);
    pulse_start();
    wait_state("rst.meas", ST_MEAS, 100);
    tick(5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_all_low("rst");
    check("rst.rd_data", rd_data, 0);
    rd_check("rst.tbl0", 0);
    rd_check("rst.tbl1", 1);
    rd_check("rst.tbl2", 2);
    exp_q.push_back(10'd300); exp_q.push_back(10'd300); exp_q.push_back(10'd300);
    nf0 = nf_rises;
    pulse_start();
    wait_done("rst.fresh_done", 1000);
    check("rst.fresh_res_valid", res_valid, 1);
    tick();
    check("rst.fresh_nf_count", 32'(nf_rises - nf0), 2);
    rd_check("rst.fresh_tbl0", 0);
    rd_check("rst.fresh_tbl1", 1);
    rd_check("rst.fresh_tbl2", 2);

`ifdef LEARN_AVG_EN
    // window amplitudes 10, 11, 11, 11 average to 11
    exp_q.push_back(10'd11); exp_q.push_back(10'd11); exp_q.push_back(10'd11);
    avg_pat = 1'b1;
    pulse_start();
    wait_done("avg.done", 2000);
    tick();
    avg_pat = 1'b0;
    rd_check("avg.tbl0", 0);
    rd_check("avg.tbl1", 1);
    rd_check("avg.tbl2", 2);
`endif

    check("scoreboard.empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
